// File: rtl/cla_seq_wide_adder_if.sv
// Handshake bundle for cla_seq_wide_adder: operand request channel and result channel.
// The sub request bit exists only when CLA_SEQ_SUB_EN is defined.
interface cla_seq_wide_adder_if #(
    parameter int W = 64
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
`ifdef CLA_SEQ_SUB_EN
    logic         sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s_out;
    logic         c_out;
    logic         busy;

    modport master (
        output in_valid, a, b, c_in,
`ifdef CLA_SEQ_SUB_EN
        output sub,
`endif
        output out_ready,
        input  in_ready, out_valid, s_out, c_out, busy
    );

    modport slave (
        input  in_valid, a, b, c_in,
`ifdef CLA_SEQ_SUB_EN
        input  sub,
`endif
        input  out_ready,
        output in_ready, out_valid, s_out, c_out, busy
    );
endinterface

// File: rtl/cla_seq_wide_adder.sv
// Multi-cycle wide adder: one SLICE-bit add-with-carry per cycle, LSB slice first.
// Optional macro CLA_SEQ_SUB_EN adds a sub request bit (a - b via ~b and carry-in 1).
module cla_seq_wide_adder #(
    parameter int SLICE = 16,
    parameter int WORDS = 4
) (
    input logic                 clk,
    input logic                 rst,
    cla_seq_wide_adder_if.slave bus
);
    localparam int W  = SLICE * WORDS;
    localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic [W-1:0]  result;
    logic [W-1:0]  result_next;
    logic          carry;
    logic [CW-1:0] cnt;
    logic          in_ready_r;
    logic          out_valid_r;
    logic          busy_r;
    logic          c_out_r;
    logic [SLICE:0] slice_sum;

    assign slice_sum = {1'b0, a_reg[SLICE-1:0]} + {1'b0, b_reg[SLICE-1:0]}
                     + {{SLICE{1'b0}}, carry};

    // The new slice enters at the top; after WORDS shifts the sum sits LSB-aligned.
    if (WORDS == 1) begin : g_single
        assign result_next = slice_sum[SLICE-1:0];
    end else begin : g_multi
        assign result_next = {slice_sum[SLICE-1:0], result[W-1:SLICE]};
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            result      <= '0;
            c_out_r     <= 1'b0;
            cnt         <= '0;
            carry       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg      <= bus.a;
                        cnt        <= '0;
`ifdef CLA_SEQ_SUB_EN
                        b_reg      <= bus.sub ? ~bus.b : bus.b;
                        carry      <= bus.sub ? 1'b1 : bus.c_in;
`else
                        b_reg      <= bus.b;
                        carry      <= bus.c_in;
`endif
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    a_reg  <= a_reg >> SLICE;
                    b_reg  <= b_reg >> SLICE;
                    result <= result_next;
                    carry  <= slice_sum[SLICE];
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(WORDS - 1)) begin
                        c_out_r     <= slice_sum[SLICE];
                        busy_r      <= 1'b0;
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: a_reg/b_reg are left out of reset; they are always loaded on accept before being read.

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.busy      = busy_r;
    assign bus.s_out     = result;
    assign bus.c_out     = c_out_r;
endmodule

// File: tb/tb_cla_seq_wide_adder.sv
// Directed self-checking bench for cla_seq_wide_adder (WORDS=4, W=64) with a result scoreboard.
// Define CLA_SEQ_SUB_EN for both bench and RTL to exercise subtraction.
module tb_cla_seq_wide_adder;
    localparam int SLICE = 16;
    localparam int WORDS = 4;
    localparam int W     = SLICE * WORDS;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    exp_t sb[$];

    cla_seq_wide_adder_if #(.W(W)) bus ();

    cla_seq_wide_adder #(.SLICE(SLICE), .WORDS(WORDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                            input logic sub);
        logic [W:0] full;
        if (sub) full = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
        else     full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        sb.push_back('{s: full[W-1:0], c: full[W]});
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        check({tag, "_sb_nonempty"}, W'(sb.size() != 0), W'(1));
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_s_out"}, bus.s_out, e.s);
            check({tag, "_c_out"}, W'(bus.c_out), W'(e.c));
        end
    endtask

    // Present an operation, wait (bounded) for acceptance, and record its expected result.
    task automatic start_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin, input logic sub);
        int k = 0;
        bus.a        = a;
        bus.b        = b;
        bus.c_in     = cin;
`ifdef CLA_SEQ_SUB_EN
        bus.sub      = sub;
`endif
        bus.in_valid = 1'b1;
        while (!bus.in_ready && k < 50) begin
            step();
            k++;
        end
        check({tag, "_accept_in_time"}, W'(bus.in_ready), W'(1));
        push_exp(a, b, cin, sub);
        step();
        bus.in_valid = 1'b0;
    endtask

    // Called right after the accept edge: measure latency and busy span, then check the result.
    task automatic finish_op(input string tag);
        int lat = 0;
        int busy_cnt = 0;
        while (!bus.out_valid && lat < 20) begin
            if (bus.busy) busy_cnt++;
            step();
            lat++;
        end
        check({tag, "_latency"}, W'(lat), W'(WORDS));
        check({tag, "_busy_cycles"}, W'(busy_cnt), W'(WORDS));
        bus.out_ready = 1'b1;
        pop_check(tag);
        step();
        bus.out_ready = 1'b0;
        check({tag, "_release_out_valid"}, W'(bus.out_valid), W'(0));
        check({tag, "_release_in_ready"}, W'(bus.in_ready), W'(1));
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub);
        start_op(tag, a, b, cin, sub);
        finish_op(tag);
    endtask

    initial begin
        int acc_cyc[$];
        int n_out;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.c_in      = 1'b0;
`ifdef CLA_SEQ_SUB_EN
        bus.sub       = 1'b0;
`endif

        // Reset state
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_in_ready", W'(bus.in_ready), W'(1));
        check("rst_out_valid", W'(bus.out_valid), W'(0));
        check("rst_busy", W'(bus.busy), W'(0));
        check("rst_s_out", bus.s_out, '0);
        check("rst_c_out", W'(bus.c_out), W'(0));

        // Carry across slice boundary, then full-width ripples
        run_op("slice_carry", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0);
        run_op("ripple_cin", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0);
        run_op("msb_carry", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0);
        run_op("mixed", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0);

        // Backpressure: result held while new requests are ignored
        start_op("bp", 64'hDEAD_BEEF_0000_FFFF, 64'h0000_0001_FFFF_0001, 1'b0, 1'b0);
        for (int i = 0; i < 20 && !bus.out_valid; i++) step();
        check("bp_out_valid_rise", W'(bus.out_valid), W'(1));
        for (int i = 0; i < 5; i++) begin
            bus.a        = 64'(i + 100);
            bus.b        = 64'(i * 3);
            bus.in_valid = (i % 2 == 0);
            step();
            check("bp_hold_out_valid", W'(bus.out_valid), W'(1));
            check("bp_hold_in_ready", W'(bus.in_ready), W'(0));
            check("bp_hold_s_out", bus.s_out, sb[0].s);
            check("bp_hold_c_out", W'(bus.c_out), W'(sb[0].c));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        pop_check("bp");
        step();
        bus.out_ready = 1'b0;
        check("bp_release_in_ready", W'(bus.in_ready), W'(1));
        check("bp_release_busy", W'(bus.busy), W'(0));

        // Reset during the second RUN cycle aborts the operation
        start_op("abort", 64'h1234, 64'h1, 1'b0, 1'b0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb.delete();
        check("abort_in_ready", W'(bus.in_ready), W'(1));
        check("abort_out_valid", W'(bus.out_valid), W'(0));
        check("abort_busy", W'(bus.busy), W'(0));
        check("abort_s_out", bus.s_out, '0);
        check("abort_c_out", W'(bus.c_out), W'(0));
        run_op("post_abort", 64'h2, 64'h3, 1'b0, 1'b0);

        // Back-to-back with in_valid and out_ready held high
        n_out         = 0;
        bus.a         = 64'h1;
        bus.b         = 64'h1;
        bus.c_in      = 1'b0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (bus.in_ready && bus.in_valid) begin
                push_exp(bus.a, bus.b, bus.c_in, 1'b0);
                acc_cyc.push_back(cyc);
            end
            if (bus.out_valid && bus.out_ready) begin
                pop_check("b2b");
                n_out++;
            end
            step();
            if (acc_cyc.size() >= 2) bus.in_valid = 1'b0;
            else if (acc_cyc.size() == 1) bus.a = 64'hFFFF;
        end
        bus.out_ready = 1'b0;
        check("b2b_accepts", W'(acc_cyc.size()), W'(2));
        check("b2b_results", W'(n_out), W'(2));
        if (acc_cyc.size() == 2) check("b2b_spacing", W'(acc_cyc[1] - acc_cyc[0]), W'(WORDS + 2));

`ifdef CLA_SEQ_SUB_EN
        run_op("sub_neg", 64'h5, 64'h7, 1'b0, 1'b1);
        run_op("sub_pos", 64'h7, 64'h5, 1'b0, 1'b1);
        run_op("sub_off", 64'h5, 64'h7, 1'b1, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/cla_seq_wide_adder.md
Name: cla_seq_wide_adder

Overview:
- Multi-cycle wide adder controller: accepts two WORDS×16-bit operands over a valid/ready handshake.
- Sequences one internal 16-bit add-with-carry slice over the operands, one slice per cycle, LSB slice first.
- Keeps a registered inter-slice carry and returns the full sum plus carry-out over a second valid/ready handshake.
- Sits between the arithmetic datapath's wide-operand producers and consumers; trades latency for a single 16-bit carry-lookahead slice instead of a full-width adder.

Parameters:
- SLICE, 16, width of the per-cycle adder slice in bits.
- WORDS, 4, number of slices per operation (operand width W = SLICE*WORDS); legal range 1..16.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands a, b, c_in present.
- in_ready  output  1  block can accept an operation.
- a  input  W  operand A.
- b  input  W  operand B.
- c_in  input  1  carry into slice 0.
- out_valid  output  1  s_out and c_out hold the completed result.
- out_ready  input  1  consumer accepts the result.
- s_out  output  W  sum, (a + b + c_in) mod 2^W.
- c_out  output  1  carry out of the top slice.
- busy  output  1  high in RUN state.

Interface: one clock, clk; reset is synchronous and active-high, named rst. No other clock or reset.

Behaviour:
- Reset (rst=1 at an edge) forces: state IDLE, in_ready=1, out_valid=0, busy=0, s_out=0, c_out=0, slice counter=0, carry register=0. rst has priority over all other inputs in every state, including mid-RUN (aborts the operation, no output produced).
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1.
  - On an edge with in_valid=1: capture a, b into operand shift registers, carry register←c_in, counter←0, go to RUN.
  - With in_valid=0: stay in IDLE.
- RUN: in_ready=0, busy=1. Each edge:
  - {cy, sum16} = a_reg[SLICE-1:0] + b_reg[SLICE-1:0] + carry, computed at SLICE+1-bit width.
  - Shift a_reg and b_reg right by SLICE.
  - Shift sum16 into the top of the result register (result shifts right by SLICE).
  - carry←cy; counter←counter+1.
  - On the edge where counter==WORDS-1: c_out←cy, go to DONE.
- DONE: out_valid=1, in_ready=0, s_out and c_out stable.
  - On an edge with out_ready=1: go to IDLE, out_valid←0.
  - With out_ready=0: hold indefinitely; s_out and c_out must not change.
- Latency: out_valid rises exactly WORDS cycles after the accepting edge. For WORDS=1, out_valid rises the cycle after accept.
- Throughput: one operation per WORDS+2 cycles minimum (accept edge, WORDS RUN edges, release edge). There is no accept in DONE, even with out_ready=1.
- in_valid asserted during RUN or DONE is ignored. The producer must hold its request until in_ready=1.
- s_out is contractually valid only while out_valid=1. Intermediate values during RUN are not checked.
- Counter width is clog2(WORDS) bits, minimum 1; it never wraps within an operation.
- Arithmetic: unsigned modulo 2^W. No overflow flag in the base configuration.

Optional Feature:
- Macro: CLA_SEQ_SUB_EN.
- Defined:
  - Adds port sub (input, 1), sampled together with a and b on the accept edge.
  - sub=1 loads b_reg←~b and carry←1; c_in is ignored. Result is a − b mod 2^W; c_out=1 means no borrow (a ≥ b unsigned).
  - sub=0 behaves exactly as the base configuration.
- Undefined: the sub port does not exist; addition only.

Test Plan (WORDS=4, W=64):
- Carry across a slice boundary: a=0x0000_0000_0000_FFFF, b=0x1, c_in=0 accepted at edge t → out_valid=1 after edge t+4, s_out=0x0000_0000_0001_0000, c_out=0, busy=1 for exactly 4 cycles.
- Full-width ripple: a=0xFFFF_FFFF_FFFF_FFFF, b=0, c_in=1 → s_out=0x0, c_out=1; a=0x8000_0000_0000_0000, b=0x8000_0000_0000_0000, c_in=0 → s_out=0, c_out=1.
- Backpressure: complete an add, hold out_ready=0 for 5 cycles while pulsing in_valid with new operands → out_valid stays 1, s_out/c_out unchanged, in_ready=0, pulses not accepted. Raise out_ready → in_ready=1 on the next cycle.
- Reset mid-operation: accept a=0x1234, b=0x1; assert rst during the second RUN cycle → next cycle in_ready=1, out_valid=0, busy=0, s_out=0, c_out=0. A following op a=0x2, b=0x3 yields s_out=0x5, c_out=0.
- Back-to-back: in_valid and out_ready held at 1 with ops (1+1), (0xFFFF+1) → accepts spaced 6 cycles apart, results 0x2 then 0x1_0000, both with c_out=0.
- CLA_SEQ_SUB_EN: a=5, b=7, sub=1 → s_out=0xFFFF_FFFF_FFFF_FFFE, c_out=0; a=7, b=5, sub=1 → s_out=0x2, c_out=1; sub=0, a=5, b=7, c_in=1 → s_out=0xD.
